// File: rtl/lmcnt_p.sv
// Local-memory sequencer: streams A/B operands from two local memories into the NPU
// and writes the NPU results back into a third memory, with sticky status flags.
module lmcnt_p #(
   parameter int DW = 8,
   parameter int AW = 10,
   parameter int NM = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    soft_reset_i,
   input  logic                    start_i,
   input  logic [$clog2(NM)-1:0]   a_sel_i,
   input  logic [$clog2(NM)-1:0]   b_sel_i,
   input  logic [$clog2(NM)-1:0]   c_sel_i,
   input  logic [AW-1:0]           a_base_i,
   input  logic [AW-1:0]           b_base_i,
   input  logic [AW-1:0]           c_base_i,
   input  logic [AW:0]             len_i,
   output logic                    busy_o,
   output logic                    finish_o,
   output logic                    cfg_err_o,
   output logic                    overrun_o,
   output logic [NM*AW-1:0]        m_radr_o,
   input  logic [NM*DW-1:0]        m_rdata_i,
   output logic [NM-1:0]           m_wr_o,
   output logic [AW-1:0]           m_wadr_o,
   output logic [DW-1:0]           m_wdata_o,
   output logic                    npu_en_o,
   output logic [DW-1:0]           a_rdata_o,
   output logic [DW-1:0]           b_rdata_o,
   input  logic                    lm_en_i,
   input  logic [DW-1:0]           c_wdata_i
);

   localparam int SW = $clog2(NM);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            clr;
   logic [SW-1:0]   a_sel_q, b_sel_q, c_sel_q;
   logic [AW-1:0]   a_base_q, b_base_q, c_base_q;
   logic [AW:0]     len_q;
   logic [AW:0]     rcnt_q, rcnt_d, wcnt_q, wcnt_d;
   logic            cfg_err_q, cfg_err_d, overrun_q, overrun_d;
   logic            rv_q, npu_en_q;
   logic [DW-1:0]   a_rdata_q, b_rdata_q;
   logic            start_ok, issue, wr_ok;
   logic [AW-1:0]   a_addr, b_addr;
   logic [DW-1:0]   rdata_w [2**SW];

   assign clr = reset_i | soft_reset_i;

   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      wcnt_d    = wcnt_q;
      cfg_err_d = cfg_err_q;
      overrun_d = overrun_q;
      issue     = 1'b0;
      start_ok  = 1'b0;
      wr_ok     = lm_en_i && !clr && (state_q == S_RUN || state_q == S_DRAIN)
                  && (wcnt_q < len_q);
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               start_ok  = 1'b1;
               rcnt_d    = '0;
               wcnt_d    = '0;
               cfg_err_d = (c_sel_i == '0);
               overrun_d = 1'b0;
               state_d   = (len_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            issue  = 1'b1;
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q + 1'b1 == len_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // the operand still on npu_en_o counts as in flight
            if (wcnt_q == len_q && !rv_q && !npu_en_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (wr_ok) wcnt_d = wcnt_q + 1'b1;
      if (lm_en_i && !wr_ok) overrun_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q   <= S_IDLE;
         rcnt_q    <= '0;
         wcnt_q    <= '0;
         cfg_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         wcnt_q    <= wcnt_d;
         cfg_err_q <= cfg_err_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         a_sel_q  <= '0;
         b_sel_q  <= '0;
         c_sel_q  <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         c_base_q <= '0;
         len_q    <= '0;
      end else if (start_ok) begin
         a_sel_q  <= a_sel_i;
         b_sel_q  <= b_sel_i;
         c_sel_q  <= c_sel_i;
         a_base_q <= a_base_i;
         b_base_q <= b_base_i;
         c_base_q <= c_base_i;
         len_q    <= len_i;
      end
   end

   // two-stage read pipeline: memory latency, then operand register
   always_ff @(posedge clk_i) begin
      if (clr) begin
         rv_q      <= 1'b0;
         npu_en_q  <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         rv_q     <= issue;
         npu_en_q <= rv_q;
         if (rv_q) begin
            a_rdata_q <= rdata_w[a_sel_q];
            b_rdata_q <= rdata_w[b_sel_q];
         end
      end
   end

   assign a_addr = a_base_q + rcnt_q[AW-1:0];
   assign b_addr = b_base_q + rcnt_q[AW-1:0];

   generate
      for (genvar gi = 0; gi < 2**SW; gi++) begin : g_rd
         if (gi < NM) begin : g_real
            assign rdata_w[gi] = m_rdata_i[gi*DW +: DW];
            assign m_radr_o[gi*AW +: AW] =
               (b_sel_q == SW'(gi) && b_sel_q != a_sel_q) ? b_addr : a_addr;
            assign m_wr_o[gi] = wr_ok && (c_sel_q != '0) && (c_sel_q == SW'(gi));
         end else begin : g_pad
            assign rdata_w[gi] = '0;
         end
      end
   endgenerate

   assign m_wadr_o  = c_base_q + wcnt_q[AW-1:0];
   assign m_wdata_o = c_wdata_i;
   assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign finish_o  = (state_q == S_DONE);
   assign cfg_err_o = cfg_err_q;
   assign overrun_o = overrun_q;
   assign npu_en_o  = npu_en_q;
   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: tb/tb_lmcnt_p.sv
// Randomized bench for lmcnt_p: behavioural memories plus a job-level reference model
// that predicts addresses, operands, writes, status flags and completion timing.
module tb_lmcnt_p;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int NM = 4;
   localparam int SW = 2;
   localparam int DEPTH = 1 << AW;

   logic              clk_i = 1'b0;
   logic              reset_i, soft_reset_i, start_i;
   logic [SW-1:0]     a_sel_i, b_sel_i, c_sel_i;
   logic [AW-1:0]     a_base_i, b_base_i, c_base_i;
   logic [AW:0]       len_i;
   logic              busy_o, finish_o, cfg_err_o, overrun_o;
   logic [NM*AW-1:0]  m_radr_o;
   logic [NM*DW-1:0]  m_rdata_i;
   logic [NM-1:0]     m_wr_o;
   logic [AW-1:0]     m_wadr_o;
   logic [DW-1:0]     m_wdata_o;
   logic              npu_en_o;
   logic [DW-1:0]     a_rdata_o, b_rdata_o;
   logic              lm_en_i;
   logic [DW-1:0]     c_wdata_i;

   logic [DW-1:0]     mem [NM][DEPTH];
   logic              init_mem;
   int                n_checks = 0;
   int                n_fail = 0;
   int                job_no = 0;

   always #5 clk_i = ~clk_i;

   lmcnt_p #(.DW(DW), .AW(AW), .NM(NM)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .soft_reset_i(soft_reset_i), .start_i(start_i),
      .a_sel_i(a_sel_i), .b_sel_i(b_sel_i), .c_sel_i(c_sel_i),
      .a_base_i(a_base_i), .b_base_i(b_base_i), .c_base_i(c_base_i), .len_i(len_i),
      .busy_o(busy_o), .finish_o(finish_o), .cfg_err_o(cfg_err_o), .overrun_o(overrun_o),
      .m_radr_o(m_radr_o), .m_rdata_i(m_rdata_i), .m_wr_o(m_wr_o),
      .m_wadr_o(m_wadr_o), .m_wdata_o(m_wdata_o), .npu_en_o(npu_en_o),
      .a_rdata_o(a_rdata_o), .b_rdata_o(b_rdata_o), .lm_en_i(lm_en_i), .c_wdata_i(c_wdata_i)
   );

   // local memories: one-cycle registered read, synchronous write
   always @(posedge clk_i) begin
      for (int i = 0; i < NM; i++) begin
         m_rdata_i[i*DW +: DW] <= mem[i][m_radr_o[i*AW +: AW]];
         if (init_mem) begin
            for (int j = 0; j < DEPTH; j++) mem[i][j] <= DW'($urandom);
         end else if (m_wr_o[i]) begin
            mem[i][m_wadr_o] <= m_wdata_o;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s job=%0d got=%0h exp=%0h", tag, job_no, got, exp);
      end
   endtask

   task automatic scramble_cfg();
      a_sel_i  = SW'($urandom);
      b_sel_i  = SW'($urandom);
      c_sel_i  = SW'($urandom);
      a_base_i = AW'($urandom);
      b_base_i = AW'($urandom);
      c_base_i = AW'($urandom);
      len_i    = (AW+1)'($urandom);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_finish"}, finish_o, 0);
      chk({tag, "_cfg_err"}, cfg_err_o, 0);
      chk({tag, "_overrun"}, overrun_o, 0);
      chk({tag, "_npu_en"}, npu_en_o, 0);
      chk({tag, "_a_rdata"}, a_rdata_o, 0);
      chk({tag, "_b_rdata"}, b_rdata_o, 0);
      chk({tag, "_m_wr"}, m_wr_o, 0);
   endtask

   task automatic run_job(input int asel, input int bsel, input int csel,
                          input int abase, input int bbase, input int cbase, input int len,
                          input int lm_pct, input bit mid_start, input bit soft_rst,
                          input bit extra_lm);
      logic [DW-1:0] ea[$];
      logic [DW-1:0] eb[$];
      int  w, tdone, budget, aa, ba, n_wr;
      bit  busy_m, done_m, cerr_m, ovr_m, accept, rst_now;
      logic [NM-1:0] exp_wr;
      job_no++;
      for (int k = 0; k < len; k++) begin
         aa = (abase + k) % DEPTH;
         ba = (asel == bsel) ? aa : (bbase + k) % DEPTH;
         ea.push_back(mem[asel][aa]);
         eb.push_back(mem[bsel][ba]);
      end
      @(negedge clk_i);
      a_sel_i = SW'(asel); b_sel_i = SW'(bsel); c_sel_i = SW'(csel);
      a_base_i = AW'(abase); b_base_i = AW'(bbase); c_base_i = AW'(cbase);
      len_i = (AW+1)'(len);
      start_i = 1'b1; lm_en_i = 1'b0; soft_reset_i = 1'b0;
      w = 0; n_wr = 0;
      busy_m = (len > 0); done_m = (len == 0); tdone = done_m ? 1 : -1;
      cerr_m = (csel == 0); ovr_m = 1'b0;
      budget = 3 * len + 60;
      for (int t = 1; t <= budget; t++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         scramble_cfg();
         lm_en_i = ($urandom_range(99) < lm_pct);
         c_wdata_i = DW'($urandom);
         if (mid_start && t == 2 && busy_m) start_i = 1'b1;
         if (extra_lm && done_m && t == tdone) lm_en_i = 1'b1;
         rst_now = soft_rst && t == 4;
         if (rst_now) begin
            soft_reset_i = 1'b1;
            lm_en_i = 1'b1;
         end
         #1;
         accept = busy_m && (w < len) && lm_en_i && !rst_now;
         chk("busy", busy_o, busy_m);
         chk("finish", finish_o, done_m);
         chk("cfg_err", cfg_err_o, cerr_m);
         chk("overrun", overrun_o, ovr_m);
         chk("npu_en", npu_en_o, busy_m && t >= 3 && t < len + 3);
         if (busy_m && t >= 3 && t < len + 3) begin
            chk("a_rdata", a_rdata_o, ea[t-3]);
            chk("b_rdata", b_rdata_o, eb[t-3]);
         end
         if (busy_m && t <= len) begin
            aa = (abase + t - 1) % DEPTH;
            ba = (bbase + t - 1) % DEPTH;
            for (int i = 0; i < NM; i++)
               chk("m_radr", m_radr_o[i*AW +: AW],
                   (i == bsel && bsel != asel) ? ba : aa);
         end
         exp_wr = (accept && csel != 0) ? NM'(1 << csel) : '0;
         chk("m_wr", m_wr_o, exp_wr);
         if (accept) begin
            chk("m_wadr", m_wadr_o, (cbase + w) % DEPTH);
            chk("m_wdata", m_wdata_o, c_wdata_i);
         end
         if (rst_now) begin
            @(negedge clk_i);
            soft_reset_i = 1'b0;
            lm_en_i = 1'b0;
            #1;
            chk_reset_vals("soft_rst");
            $display("job %0d soft reset at cycle %0d asel=%0d bsel=%0d csel=%0d len=%0d",
                     job_no, t, asel, bsel, csel, len);
            return;
         end
         if (busy_m && t >= len + 3 && w == len) begin
            busy_m = 1'b0;
            done_m = 1'b1;
            tdone = t + 1;
         end
         if (lm_en_i && !accept) ovr_m = 1'b1;
         if (accept) begin
            w++;
            if (csel != 0) n_wr++;
         end
         if (done_m && t >= tdone + 2) break;
      end
      if (!done_m) chk("job_timeout", 0, 1);
      $display("job %0d asel=%0d bsel=%0d csel=%0d len=%0d writes=%0d done_at=%0d",
               job_no, asel, bsel, csel, len, n_wr, tdone);
   endtask

   initial begin
      int asel, bsel, csel, len;
      reset_i = 1'b1; soft_reset_i = 1'b0; start_i = 1'b0; lm_en_i = 1'b0;
      c_wdata_i = '0; init_mem = 1'b1;
      scramble_cfg();
      repeat (3) @(negedge clk_i);
      init_mem = 1'b0;
      start_i = 1'b1; lm_en_i = 1'b1;
      #1;
      chk_reset_vals("reset");
      @(negedge clk_i);
      chk_reset_vals("reset_prio");
      reset_i = 1'b0; start_i = 1'b0; lm_en_i = 1'b0;

      run_job(1, 2, 3, 0, 'h10, 'h100, 4, 100, 0, 0, 0);
      run_job(1, 2, 3, 'h3FE, 'h3FD, 'h3FF, 4, 70, 0, 0, 0);
      run_job(1, 2, 3, 5, 6, 7, 0, 100, 0, 0, 1);
      run_job(2, 1, 3, 'h20, 'h40, 'h60, 4, 80, 1, 0, 1);
      run_job(1, 2, 3, 'h30, 'h50, 'h70, 6, 100, 0, 1, 0);
      run_job(1, 2, 3, 0, 'h10, 'h100, 4, 100, 0, 0, 0);
      run_job(2, 3, 0, 8, 9, 10, 2, 100, 0, 0, 0);
      run_job(3, 3, 1, 'h3FC, 'h123, 'h10, 7, 60, 0, 0, 0);
      run_job(0, 1, 2, 100, 200, 1020, 1 << AW, 90, 0, 0, 1);

      for (int j = 0; j < 40; j++) begin
         asel = $urandom_range(NM - 1);
         bsel = $urandom_range(NM - 1);
         do csel = $urandom_range(NM - 1); while (csel == asel || csel == bsel);
         len = ($urandom_range(9) == 0) ? 0 : $urandom_range(20, 1);
         run_job(asel, bsel, csel, $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
                 $urandom_range(DEPTH - 1), len, $urandom_range(100, 50),
                 bit'($urandom_range(1)), (len >= 2) && ($urandom_range(7) == 0),
                 bit'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/lmcnt_p.md
LMCNT_P -- requirements
Module: lmcnt_p

Interface
REQ-001 Parameter DW, default 8, data width of local memories and NPU data paths, SHALL be supported over 8..32.
REQ-002 Parameter AW, default 10, local-memory address width; transfer length range SHALL be 0..2^AW.
REQ-003 Parameter NM, default 4, local memory count M0..M(NM-1), 2..8; SW = clog2(NM); M0 is read-only.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 SOFT_RESET  in  1  synchronous, active-high CPU clear, same effect as RESET.
REQ-007 START  in  1  one-cycle job start pulse.
REQ-008 A_SEL, B_SEL, C_SEL  in  SW each  source memory for A, source memory for B, destination memory for C.
REQ-009 A_BASE, B_BASE, C_BASE  in  AW each  start addresses for A, B and C.
REQ-010 LEN  in  AW+1  element count.
REQ-011 BUSY  out  1  job in progress; FINISH  out  1  sticky job-complete flag.
REQ-012 CFG_ERR  out  1  sticky flag, C_SEL==0 at START; OVERRUN  out  1  sticky flag, dropped write.
REQ-013 M_RADR  out  NM*AW  per-memory read address; M_RDATA  in  NM*DW  per-memory read data.
REQ-014 M_WR  out  NM  per-memory write strobe; M_WADR  out  AW  shared write address; M_WDATA  out  DW  shared write data.
REQ-015 NPU_EN  out  1  A_RDATA/B_RDATA valid; A_RDATA, B_RDATA  out  DW each  operands.
REQ-016 LM_EN  in  1  result valid; C_WDATA  in  DW  result.

Function
REQ-017 On START, the block SHALL latch all SEL, BASE and LEN inputs; later input changes SHALL NOT affect the running job.
REQ-018 The state machine SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-019 Transitions:
- IDLE/DONE + START, LEN>0 -> RUN, with FINISH, CFG_ERR and OVERRUN cleared.
- IDLE/DONE + START, LEN==0 -> DONE; no reads issued.
- RUN -> DRAIN after LEN read addresses have been issued.
- DRAIN -> DONE when wcnt==LEN and the read pipeline is empty.
REQ-020 START in RUN or DRAIN SHALL be ignored.
REQ-021 BUSY SHALL be 1 in RUN and DRAIN; FINISH SHALL be 1 in DONE only.
REQ-022 Read issue: in RUN, cycle k (k=0..LEN-1) SHALL present A_BASE+k on memory A_SEL and B_BASE+k on memory B_SEL, both modulo 2^AW.
REQ-023 Addressing of unselected memories and of the A_SEL==B_SEL case:
- Unselected memories SHALL receive the A address.
- If A_SEL==B_SEL, both operands SHALL use the A address and B_BASE SHALL be ignored.
REQ-024 Memory read latency is 1 cycle; A_RDATA/B_RDATA SHALL be registered from M_RDATA.
REQ-025 Operand k SHALL be valid with NPU_EN=1 exactly 2 cycles after its address issue; NPU_EN SHALL be 0 otherwise.
REQ-026 Write path: LM_EN=1 in RUN/DRAIN with wcnt<LEN SHALL do all of the following:
- assert M_WR[C_SEL] combinationally;
- drive M_WADR = C_BASE+wcnt (mod 2^AW) and M_WDATA = C_WDATA;
- increment wcnt.
REQ-027 LM_EN in IDLE/DONE, or with wcnt==LEN, SHALL produce no write and SHALL set OVERRUN.
REQ-028 C_SEL==0 latched SHALL set CFG_ERR; the job SHALL still run and count writes, but all M_WR SHALL stay 0.
REQ-029 Counters SHALL be AW+1 bits wide so that LEN=2^AW completes without aliasing.
REQ-030 LM_EN coincident with the final read issue SHALL be accepted normally.

Reset
REQ-031 RESET or SOFT_RESET SHALL force the following values on the next edge, including mid-job:
- state IDLE, rcnt=0, wcnt=0;
- BUSY=0, FINISH=0, CFG_ERR=0, OVERRUN=0;
- NPU_EN=0, A_RDATA=0, B_RDATA=0, M_WR=0.
REQ-032 Reset SHALL take priority over START and LM_EN presented in the same cycle.

Verification
REQ-033 DW=8, AW=10, NM=4, A_SEL=1 base 0, B_SEL=2 base 0x10, C_SEL=3 base 0x100, LEN=4, START at cycle n:
- M_RADR for M1 = 0..3 and for M2 = 0x10..0x13 at n+1..n+4;
- NPU_EN=1 at n+3..n+6;
- four LM_EN pulses write M3 at 0x100..0x103;
- then FINISH=1, BUSY=0.
REQ-034 A_BASE=0x3FE, LEN=4 -> A addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-035 LEN=0 START -> FINISH=1 the next cycle; NPU_EN stays 0; no M_WR.
REQ-036 Fifth LM_EN after LEN=4 writes complete -> no M_WR; OVERRUN=1. START during RUN -> ignored; latched config unchanged.
REQ-037 SOFT_RESET at the second NPU_EN cycle -> all outputs at REQ-031 values next cycle; a new START then runs a full job correctly.
REQ-038 C_SEL=0 with LEN=2 -> CFG_ERR=1; M_WR stays 0; FINISH after 2 LM_EN pulses.
